// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stage boundaries.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_e;

    // Example stage payload: instantiators pack it into WIDTH bits.
    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
    } ex_mem_t;

    localparam int unsigned EX_MEM_W = $bits(ex_mem_t);

    function automatic logic [1:0] state_occupancy(input pipe_state_e s);
        case (s)
            PS_ONE:  return 2'd1;
            PS_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_elastic_sat_counter.sv
// Saturating up-counter with synchronous clear and async active-low reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = '0;
        end else if (inc && (value_q != '1)) begin
            value_d = value_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline register with optional two-entry skid buffer,
// synchronous flush to a NOP payload and a saturating stall counter.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  NOP_VALUE = '0,
    parameter bit                SKID      = 1'b1,
    parameter int unsigned       STALL_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         occupancy,
    output logic [STALL_W-1:0] stall_cnt
);

    pipe_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic             in_fire;
    logic             out_fire;

    assign out_valid = (state_q != PS_EMPTY);
    assign out_fire  = out_valid && out_ready;
    assign in_fire   = in_valid && in_ready && !flush;
    assign out_data  = main_q;
    assign occupancy = state_occupancy(state_q);

    generate
        if (SKID) begin : g_skid
            logic [WIDTH-1:0] skid_q, skid_d;

            // Registered-only ready breaks the out_ready -> in_ready path.
            assign in_ready = (state_q != PS_FULL);

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                if (flush) begin
                    state_d = PS_EMPTY;
                    main_d  = NOP_VALUE;
                    skid_d  = NOP_VALUE;
                end else begin
                    case (state_q)
                        PS_EMPTY: begin
                            if (in_fire) begin
                                state_d = PS_ONE;
                                main_d  = in_data;
                            end
                        end
                        PS_ONE: begin
                            if (in_fire && out_fire) begin
                                main_d = in_data;
                            end else if (out_fire) begin
                                state_d = PS_EMPTY;
                            end else if (in_fire) begin
                                state_d = PS_FULL;
                                skid_d  = in_data;
                            end
                        end
                        PS_FULL: begin
                            if (out_fire) begin
                                state_d = PS_ONE;
                                main_d  = skid_q;
                            end
                        end
                        default: state_d = PS_EMPTY;
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    skid_q <= NOP_VALUE;
                end else begin
                    skid_q <= skid_d;
                end
            end
        end else begin : g_noskid
            assign in_ready = !out_valid || out_ready;

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                if (flush) begin
                    state_d = PS_EMPTY;
                    main_d  = NOP_VALUE;
                end else if (in_fire) begin
                    state_d = PS_ONE;
                    main_d  = in_data;
                end else if (out_fire) begin
                    state_d = PS_EMPTY;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PS_EMPTY;
            main_q  <= NOP_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    sat_counter #(
        .W (STALL_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid && !out_ready),
        .clear (1'b0),
        .value (stall_cnt)
    );

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised elastic pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB), replacing fixed per-stage registers driven by a global enable. Carries an opaque packed payload with valid/ready handshaking and an optional two-entry skid buffer, so back-pressure does not need a combinational stall path across the whole pipeline. It also provides a synchronous flush that loads a NOP payload, an occupancy output and a saturating stall counter for performance monitoring.

## Interface
- WIDTH, 32, payload width in bits (≥1).
- NOP_VALUE, '0, payload loaded on reset/flush (WIDTH bits).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- STALL_W, 16, stall counter width (≥1).
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  payload valid to downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  payload to downstream.
- occupancy  out  2  entries held (0..2; max 1 when SKID=0).
- stall_cnt  out  STALL_W  saturating count of stalled output cycles.

## Operation
- Input fire = in_valid && in_ready && !flush. Output fire = out_valid && out_ready.
- Entries: main (drives out_data/out_valid), skid (present only if SKID=1).
- States (SKID=1): EMPTY, ONE, FULL. occupancy = 0/1/2 accordingly.
  - EMPTY: input fire → ONE, main ← in_data.
  - ONE: both fire → ONE, main ← in_data; output fire only → EMPTY; input fire only → FULL, skid ← in_data; neither → ONE.
  - FULL: output fire → ONE, main ← skid; otherwise hold. No input fire is possible because in_ready = 0.
- in_ready (SKID=1) = state != FULL, from registers only.
- SKID=0: states EMPTY/ONE only. in_ready = !out_valid || out_ready (combinational). Input fire loads main.
- flush: next state EMPTY; main and skid payloads ← NOP_VALUE. Any input handshake in the flush cycle is dropped. An output fire in the flush cycle completes normally, since out_valid is registered and not retracted.
- out_data:
  - NOP_VALUE after reset/flush.
  - After draining to EMPTY it holds the last delivered payload; consumers must qualify it with out_valid.
- stall_cnt: +1 each cycle with out_valid && !out_ready. Saturates at 2^STALL_W−1. Cleared only by reset, not by flush.
- Ordering: strict FIFO. No payload is duplicated or lost except by flush.

## Timing
- Reset values: out_valid 0, out_data NOP_VALUE, occupancy 0, stall_cnt 0, in_ready 1 (SKID=1) or 1 via the combinational path (SKID=0).
- Latency: input fire in cycle N → out_valid = 1 with that payload in cycle N+1.
- Throughput: 1 payload/cycle while out_ready is held high, in both modes.
- SKID=1: out_ready → in_ready has no combinational path. in_ready falls the cycle after ONE + stall + input fire, and rises the cycle after an output fire from FULL.
- Simultaneous flush and in_valid: flush wins; occupancy = 0 next cycle.
- Reset asserted mid-transfer: all state clears asynchronously, with no partial update.

## Structure
- Shared package pipe_pkg holds typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_FULL} pipe_state_e. Stage payload structs (e.g. the EX/MEM bundle) are also defined there and packed into WIDTH by instantiators.
- One natural sub-module: sat_counter (parameter W; inc, clear, value) for stall_cnt.
- SKID is selected by a generate block; the skid register is absent when SKID=0.

## Test plan
- Reset then idle: out_valid = 0, out_data = NOP_VALUE, occupancy = 0, in_ready = 1, stall_cnt = 0.
- Streaming (SKID=1, out_ready = 1), inputs 0x1,0x2,0x3 on consecutive cycles → outputs 0x1,0x2,0x3 one cycle later each, occupancy stays 1, stall_cnt = 0.
- Back-pressure (SKID=1): push 0xA, 0xB while out_ready = 0 → occupancy 2, in_ready = 0, stall_cnt increments each stalled cycle. Raise out_ready → 0xA, then 0xB, then in_ready = 1.
- Flush in FULL with in_valid = 1 (0xC) → next cycle occupancy = 0, out_valid = 0, out_data = NOP_VALUE, and 0xC is never output.
- SKID=0, out_ready = 0 with entry held → in_ready = 0 combinationally. Assert out_ready and in_valid together → new payload replaces main in the same cycle as the output fire.
- STALL_W = 2, stall 6 cycles → stall_cnt saturates at 3. Apply flush → stall_cnt stays 3.
